// File: rtl/mem_bist_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bist_pkg
//  Description : Shared types, constants and helpers for the memory BIST
//                controller (state/pattern enums, LFSR mask, parity).
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_bist_pkg;

   // Controller states; width fixed so encodings are stable across tools
   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_GAP   = 3'd2,
      ST_READ  = 3'd3,
      ST_DRAIN = 3'd4,
      ST_DONE  = 3'd5
   } bist_state_e;

   // Pattern selection as presented on pattern_sel
   typedef enum logic [1:0] {
      PAT_LFSR  = 2'b00,
      PAT_ADDR  = 2'b01,
      PAT_CHECK = 2'b10,
      PAT_NLFSR = 2'b11
   } bist_pat_e;

   localparam logic [7:0] LFSR_MASK = 8'hB8;
   localparam logic [7:0] c_PAT_55  = 8'h55;
   localparam logic [7:0] c_PAT_AA  = 8'hAA;

   // Odd parity bit: makes the 9-bit word carry an odd number of ones
   function automatic logic odd_par(input logic [7:0] b);
      return ~^b;
   endfunction

   // One step of the right-shifting Galois LFSR
   function automatic logic [7:0] lfsr_step(input logic [7:0] s);
      return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/bist_pattern_gen.sv
`default_nettype none
// ============================================================================
//  Module      : bist_pattern_gen
//  Description : Byte pattern source for the BIST. Holds the LFSR and muxes
//                between LFSR, address-fold, checkerboard and inverted LFSR.
//                When reseed is high the seed is used combinationally in the
//                same cycle, so the first word of a phase sees the seed.
//  Revision    : 1.0 - initial release
// ============================================================================
module bist_pattern_gen
   import mem_bist_pkg::*;
#(
   parameter int         ADDR_W    = 16,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reseed,
   input  logic              advance,
   input  bist_pat_e         pattern_sel,
   input  logic [ADDR_W-1:0] addr,
   output logic [7:0]        pattern
);

   logic [7:0]  r_lfsr;
   logic [7:0]  w_cur;
   logic [15:0] w_a16;

   assign w_cur = reseed ? LFSR_SEED : r_lfsr;
   assign w_a16 = 16'(addr);

   // LFSR state: steps once per issued word, restarts from the seed on reseed
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_lfsr <= LFSR_SEED;
      end else if (advance) begin
         r_lfsr <= lfsr_step(w_cur);
      end else if (reseed) begin
         r_lfsr <= LFSR_SEED;
      end
   end

   // Pattern mux for the word currently being issued
   always_comb begin
      pattern = w_cur;
      case (pattern_sel)
         PAT_LFSR:  pattern = w_cur;
         PAT_ADDR:  pattern = w_a16[7:0] ^ w_a16[15:8];
         PAT_CHECK: pattern = w_a16[0] ? c_PAT_AA : c_PAT_55;
         PAT_NLFSR: pattern = ~w_cur;
         default:   pattern = w_cur;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_bist_ctrl
//  Description : Memory self-test initiator. Writes a pattern over a window,
//                reads it back and compares data plus odd parity, reporting
//                pass and saturating ok/error counts. All outputs registered.
//                Optional macro BIST_FAIL_LOG_EN adds first-mismatch capture
//                (fail_addr / fail_exp / fail_got).
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bist_ctrl
   import mem_bist_pkg::*;
#(
   parameter int         ADDR_W    = 16,
   parameter int         DATA_W    = 8,
   parameter int         CNT_W     = 16,
   parameter logic [7:0] LFSR_SEED = 8'hA5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W-1:0] len_m1,
   input  logic [1:0]        pattern_sel,
   output logic              mem_write,
   output logic              mem_read,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W:0]   mem_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [CNT_W-1:0]  err_cnt,
   output logic [CNT_W-1:0]  ok_cnt
`ifdef BIST_FAIL_LOG_EN
   ,
   output logic [ADDR_W-1:0] fail_addr,
   output logic [DATA_W:0]   fail_exp,
   output logic [DATA_W:0]   fail_got
`endif
);

   bist_state_e       r_state;
   bist_state_e       w_state_nxt;

   logic [ADDR_W-1:0] r_base;
   logic [ADDR_W-1:0] r_len;
   bist_pat_e         r_sel;
   logic [ADDR_W-1:0] r_ptr;     // next address to issue
   logic [ADDR_W-1:0] r_rem;     // words still to issue after the current one

   logic              w_accept;
   logic              w_wr_d;
   logic              w_rd_d;
   logic              w_reseed;
   logic              w_adv;
   logic [ADDR_W-1:0] w_iss_addr;
   logic [ADDR_W-1:0] w_len_src;
   logic              w_busy_d;
   logic              w_done_d;
   bist_pat_e         w_sel;
   logic [7:0]        w_pat;

   logic [7:0]        r_rd_exp;  // pattern of the read in flight
   logic [7:0]        r_cmp_exp; // aligned with mem_rdata
   logic              r_cmp_vld;
   logic [DATA_W:0]   w_exp_word;
   logic              w_match;
   logic [CNT_W-1:0]  w_err_nxt;
   logic [CNT_W-1:0]  w_ok_nxt;

   assign w_accept   = (r_state == ST_IDLE) && start;
   assign w_sel      = (r_state == ST_IDLE) ? bist_pat_e'(pattern_sel) : r_sel;
   assign w_len_src  = (r_state == ST_IDLE) ? len_m1 : r_len;
   assign w_adv      = w_wr_d | w_rd_d;
   assign w_exp_word = (DATA_W+1)'({odd_par(r_cmp_exp), r_cmp_exp});
   assign w_match    = (mem_rdata == w_exp_word);

   bist_pattern_gen #(
      .ADDR_W    (ADDR_W),
      .LFSR_SEED (LFSR_SEED)
   ) u_pat (
      .clk         (clk),
      .rst_n       (rst_n),
      .reseed      (w_reseed),
      .advance     (w_adv),
      .pattern_sel (w_sel),
      .addr        (w_iss_addr),
      .pattern     (w_pat)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: phases end when no words remain to issue
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (start) w_state_nxt = ST_WRITE;
         ST_WRITE: if (r_rem == '0) w_state_nxt = ST_GAP;
         ST_GAP:   w_state_nxt = ST_READ;
         ST_READ:  if (r_rem == '0) w_state_nxt = ST_DRAIN;
         ST_DRAIN: w_state_nxt = ST_DONE;
         ST_DONE:  w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Output decode: next values for the registered strobes and address
   always_comb begin
      w_wr_d     = 1'b0;
      w_rd_d     = 1'b0;
      w_reseed   = 1'b0;
      w_iss_addr = r_ptr;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_wr_d     = 1'b1;
               w_reseed   = 1'b1;
               w_iss_addr = base_addr;
            end
         end
         ST_WRITE: w_wr_d = (r_rem != '0);
         ST_GAP: begin
            w_rd_d     = 1'b1;
            w_reseed   = 1'b1;
            w_iss_addr = r_base;
         end
         ST_READ:  w_rd_d = (r_rem != '0);
         default: begin
            w_wr_d = 1'b0;
         end
      endcase
      w_busy_d = (w_state_nxt == ST_WRITE) || (w_state_nxt == ST_GAP) ||
                 (w_state_nxt == ST_READ)  || (w_state_nxt == ST_DRAIN);
      w_done_d = (w_state_nxt == ST_DONE);
   end

   // Latched run configuration
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_base <= '0;
         r_len  <= '0;
         r_sel  <= PAT_LFSR;
      end else if (w_accept) begin
         r_base <= base_addr;
         r_len  <= len_m1;
         r_sel  <= bist_pat_e'(pattern_sel);
      end
   end

   // Address pointer and remaining-word counter; address wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
         r_rem <= '0;
      end else if (w_reseed) begin
         r_ptr <= w_iss_addr + ADDR_W'(1);
         r_rem <= w_len_src;
      end else if (w_adv) begin
         r_ptr <= r_ptr + ADDR_W'(1);
         r_rem <= r_rem - ADDR_W'(1);
      end
   end

   // Registered memory interface and status outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_write <= 1'b0;
         mem_read  <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
      end else begin
         mem_write <= w_wr_d;
         mem_read  <= w_rd_d;
         mem_addr  <= w_adv ? w_iss_addr : '0;
         mem_wdata <= w_wr_d ? DATA_W'(w_pat) : '0;
         busy      <= w_busy_d;
         done      <= w_done_d;
         if (w_accept) begin
            pass <= 1'b0;
         end else if (w_done_d) begin
            pass <= (w_err_nxt == '0);
         end
      end
   end

   // Expected-byte pipeline: one stage behind the read strobe, like mem_rdata
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_exp  <= '0;
         r_cmp_exp <= '0;
         r_cmp_vld <= 1'b0;
      end else begin
         r_rd_exp  <= w_rd_d ? w_pat : '0;
         r_cmp_exp <= r_rd_exp;
         r_cmp_vld <= mem_read;
      end
   end

   // Saturating counter updates from the compare stage
   always_comb begin
      w_err_nxt = err_cnt;
      w_ok_nxt  = ok_cnt;
      if (r_cmp_vld) begin
         if (w_match) begin
            if (ok_cnt != '1) w_ok_nxt = ok_cnt + CNT_W'(1);
         end else begin
            if (err_cnt != '1) w_err_nxt = err_cnt + CNT_W'(1);
         end
      end
   end

   // Counter registers, cleared when a run is accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt <= '0;
         ok_cnt  <= '0;
      end else if (w_accept) begin
         err_cnt <= '0;
         ok_cnt  <= '0;
      end else begin
         err_cnt <= w_err_nxt;
         ok_cnt  <= w_ok_nxt;
      end
   end

`ifdef BIST_FAIL_LOG_EN
   logic [ADDR_W-1:0] r_cmp_addr;

   // First-mismatch capture; err_cnt==0 marks the first failing compare
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmp_addr <= '0;
         fail_addr  <= '0;
         fail_exp   <= '0;
         fail_got   <= '0;
      end else begin
         r_cmp_addr <= mem_addr;
         if (w_accept) begin
            fail_addr <= '0;
            fail_exp  <= '0;
            fail_got  <= '0;
         end else if (r_cmp_vld && !w_match && (err_cnt == '0)) begin
            fail_addr <= r_cmp_addr;
            fail_exp  <= w_exp_word;
            fail_got  <= mem_rdata;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bist_ctrl
//  Description : Self-checking bench for mem_bist_ctrl with a behavioural
//                parity memory that can corrupt chosen read words.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bist_ctrl;

   localparam logic [7:0] SEED = 8'hA5;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] base_addr = '0;
   logic [15:0] len_m1 = '0;
   logic [1:0]  pattern_sel = '0;
   logic        mem_write, mem_read;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [8:0]  mem_rdata = '0;
   logic        busy, done, pass;
   logic [15:0] err_cnt, ok_cnt;
`ifdef BIST_FAIL_LOG_EN
   logic [15:0] fail_addr;
   logic [8:0]  fail_exp, fail_got;
`endif

   mem_bist_ctrl #(
      .ADDR_W(16), .DATA_W(8), .CNT_W(16), .LFSR_SEED(SEED)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
      .len_m1(len_m1), .pattern_sel(pattern_sel), .mem_write(mem_write),
      .mem_read(mem_read), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .done(done), .pass(pass),
      .err_cnt(err_cnt), .ok_cnt(ok_cnt)
`ifdef BIST_FAIL_LOG_EN
      , .fail_addr(fail_addr), .fail_exp(fail_exp), .fail_got(fail_got)
`endif
   );

   always #5 clk = ~clk;

   // Behavioural memory: stores data with odd parity, read data one cycle later
   logic [8:0]  mem [0:65535];
   logic [15:0] flip_a0 = '0, flip_a1 = '0;
   logic [8:0]  flip_mask = '0;
   always @(posedge clk) begin
      if (mem_write) mem[mem_addr] <= {~^mem_wdata, mem_wdata};
      if (mem_read)
         mem_rdata <= mem[mem_addr] ^
                      (((mem_addr == flip_a0) || (mem_addr == flip_a1)) ? flip_mask : 9'h000);
   end

   typedef struct {
      logic [15:0] base;
      logic [15:0] len;
      logic [1:0]  sel;
      logic [15:0] fa0;
      logic [15:0] fa1;
      logic [8:0]  mask;
      int          exp_err;
      int          exp_ok;
      logic        exp_pass;
   } vec_t;

   typedef struct { logic [15:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [15:0] err; logic [15:0] ok; logic pass; } res_t;

   wr_t         wr_q[$];
   logic [15:0] rd_q[$];
   res_t        res_q[$];
   vec_t        vecs[6];

   int tests = 0;
   int fails = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   function automatic logic [7:0] m_step(input logic [7:0] s);
      logic [7:0] t;
      t = {1'b0, s[7:1]};
      if (s[0]) t = t ^ 8'hB8;
      return t;
   endfunction

   function automatic logic [7:0] m_pat(input logic [1:0] sel, input logic [7:0] l,
                                        input logic [15:0] a);
      case (sel)
         2'b00:   return l;
         2'b01:   return a[7:0] ^ a[15:8];
         2'b10:   return a[0] ? 8'hAA : 8'h55;
         default: return ~l;
      endcase
   endfunction

   // Runs one BIST pass; optionally pulses start again at edge mid_edge
   task automatic run(input vec_t v, input int mid_edge);
      int          n;
      int          edges;
      bit          seen_done;
      logic [7:0]  l;
      logic [7:0]  d;
      logic [15:0] a;
      logic [7:0]  first_exp;
      logic [15:0] first_addr;
      bit          have_first;
      wr_t         w;
      res_t        r;
      logic [15:0] ra;
      n = int'(v.len) + 1;
      l = SEED;
      have_first = 1'b0;
      first_exp = '0;
      first_addr = '0;
      flip_a0 = v.fa0; flip_a1 = v.fa1; flip_mask = v.mask;
      for (int k = 0; k < n; k++) begin
         a = v.base + 16'(k);
         d = m_pat(v.sel, l, a);
         wr_q.push_back('{a, d});
         rd_q.push_back(a);
         if (!have_first && (v.mask != 0) && ((a == v.fa0) || (a == v.fa1))) begin
            have_first = 1'b1; first_exp = d; first_addr = a;
         end
         l = m_step(l);
      end
      res_q.push_back('{16'(v.exp_err), 16'(v.exp_ok), v.exp_pass});

      @(negedge clk);
      base_addr = v.base; len_m1 = v.len; pattern_sel = v.sel; start = 1'b1;
      edges = 0; seen_done = 1'b0;
      while (!seen_done && edges < 2 * n + 40) begin
         @(posedge clk); edges++;
         @(negedge clk);
         start = (mid_edge != 0) && (edges == mid_edge);
         if (start) begin
            base_addr = 16'h7777; len_m1 = 16'h0001; pattern_sel = 2'b10;
         end
         if (mem_write && mem_read) chk("strobes_both_high", 1, 0);
         if (edges == 1) chk("busy_after_start", busy, 1);
         if (mem_write) begin
            if (wr_q.size() == 0) chk("write_extra", 1, 0);
            else begin
               w = wr_q.pop_front();
               chk("write_addr", mem_addr, w.addr);
               chk("write_data", mem_wdata, w.data);
            end
         end
         if (mem_read) begin
            if (rd_q.size() == 0) chk("read_extra", 1, 0);
            else begin
               ra = rd_q.pop_front();
               chk("read_addr", mem_addr, ra);
            end
         end
         if (done) begin
            seen_done = 1'b1;
            chk("done_latency", edges - 1, 2 * n + 2);
            chk("busy_in_done", busy, 0);
            r = res_q.pop_front();
            chk("err_cnt", err_cnt, r.err);
            chk("ok_cnt", ok_cnt, r.ok);
            chk("pass", pass, r.pass);
`ifdef BIST_FAIL_LOG_EN
            chk("fail_addr", fail_addr, have_first ? first_addr : 16'h0);
            chk("fail_exp", fail_exp, have_first ? {~^first_exp, first_exp} : 9'h0);
            chk("fail_got", fail_got,
                have_first ? ({~^first_exp, first_exp} ^ v.mask) : 9'h0);
`endif
         end
      end
      start = 1'b0;
      if (!seen_done) begin
         chk("done_timeout", 0, 1);
         res_q.delete();
      end
      chk("writes_left", wr_q.size(), 0);
      chk("reads_left", rd_q.size(), 0);
      wr_q.delete(); rd_q.delete();
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //           base      len_m1  sel    fa0       fa1       mask    err ok pass
      vecs[0] = '{16'h0010, 16'd3,  2'b00, 16'h0000, 16'h0000, 9'h000, 0, 4,  1'b1};
      vecs[1] = '{16'hFFFE, 16'd3,  2'b10, 16'h0000, 16'h0000, 9'h000, 0, 4,  1'b1};
      vecs[2] = '{16'h0010, 16'd3,  2'b00, 16'h0012, 16'h0012, 9'h001, 1, 3,  1'b0};
      vecs[3] = '{16'h0040, 16'd7,  2'b01, 16'h0045, 16'h0045, 9'h100, 1, 7,  1'b0};
      vecs[4] = '{16'h1234, 16'd0,  2'b11, 16'h0000, 16'h0000, 9'h000, 0, 1,  1'b1};
      vecs[5] = '{16'h00F8, 16'd15, 2'b01, 16'h00FA, 16'h0103, 9'h081, 2, 14, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset_outputs", |{mem_write, mem_read, mem_addr, mem_wdata, busy, done,
                             pass, err_cnt, ok_cnt}, 0);
`ifdef BIST_FAIL_LOG_EN
      chk("reset_fail_log", |{fail_addr, fail_exp, fail_got}, 0);
`endif
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         run(vecs[i], 0);
         @(negedge clk);
         chk("done_one_cycle", done, 0);
         chk("pass_held", pass, vecs[i].exp_pass);
      end

      // start pulsed mid-READ (N=8, read phase spans edges 10..17) is ignored
      begin
         vec_t v;
         v = '{16'h0100, 16'd7, 2'b00, 16'h0000, 16'h0000, 9'h000, 0, 8, 1'b1};
         run(v, 13);
      end
      // start presented while in DONE is ignored as well
      base_addr = 16'h0300; len_m1 = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 8; c++) begin
         chk("no_run_after_done_start", {busy, done, mem_write, mem_read}, 0);
         @(negedge clk);
      end
      chk("counts_unchanged_ok", ok_cnt, 8);
      chk("counts_unchanged_err", err_cnt, 0);
      chk("pass_still_held", pass, 1);

      // Reset during WRITE
      base_addr = 16'h0200; len_m1 = 16'd15; pattern_sel = 2'b00; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("writing_before_reset", mem_write, 1);
      rst_n = 1'b0;
      #1;
      chk("outputs_after_reset", |{mem_write, mem_read, mem_addr, mem_wdata, busy,
                                   done, pass, err_cnt, ok_cnt}, 0);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("no_done_in_reset", {done, busy}, 0);
      end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_after_reset", {busy, done, mem_write}, 0);
      run(vecs[0], 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
